// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : I-cache fetch port, one outstanding request via req/gnt/valid.
// Revision : 1.0
// ============================================================================
interface fetch_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    modport master (
        output if_req,
        output if_addr,
        input  if_gnt,
        input  if_valid,
        input  if_rdata
    );

    modport slave (
        input  if_req,
        input  if_addr,
        output if_gnt,
        output if_valid,
        output if_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : I-cache invalidation sweep, fetch PC ownership and redirects.
// Revision : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter int          ICACHE_SETS  = 128,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    output logic                                ready,
    output logic                                inv_we,
    output logic [$clog2(ICACHE_SETS)-1:0]      inv_idx,
    fetch_ctrl_if.master                        bus,
    input  wire logic                           stall_hold,
    input  wire logic                           hold_pc,
    input  wire logic                           flush,
    input  wire logic [31:0]                    flush_pc,
    input  wire logic                           branch_flag,
    input  wire logic [31:0]                    branch_target,
    input  wire logic                           predict,
    input  wire logic [31:0]                    predict_target,
    output logic                                inst_valid,
    output logic [31:0]                         inst,
    output logic [31:0]                         inst_pc
);

    localparam int                IDX_W      = $clog2(ICACHE_SETS);
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(ICACHE_SETS - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_pc;
    logic [31:0]        r_cap_pc;
    logic               r_ready;
    logic               r_inv_we;
    logic [IDX_W-1:0]   r_inv_idx;
    logic               r_squash;
    logic [1:0]         r_pend_prio;
    logic               r_inst_valid;
    logic [31:0]        r_inst;
    logic [31:0]        r_inst_pc;

    logic [1:0]         w_prio;
    logic [31:0]        w_target;
    logic               w_req;
    logic               w_gnt;
    logic               w_take_run;
    logic               w_take_wait;
    logic               w_deliver;

    // Fixed-priority redirect select; hold_pc masks only branch/predict.
    always_comb begin
        w_prio   = 2'd0;
        w_target = r_pc;
        if (flush) begin
            w_prio   = 2'd3;
            w_target = flush_pc;
        end else if (branch_flag && !hold_pc) begin
            w_prio   = 2'd2;
            w_target = branch_target;
        end else if (predict && !hold_pc) begin
            w_prio   = 2'd1;
            w_target = predict_target;
        end
    end

    always_comb begin
        w_req       = (r_state == S_RUN) && !stall_hold;
        w_gnt       = w_req && bus.if_gnt;
        w_take_run  = (r_state == S_RUN) && (w_prio != 2'd0);
        w_take_wait = (r_state == S_WAIT) && (w_prio != 2'd0) && (w_prio >= r_pend_prio);
        w_deliver   = (r_state == S_WAIT) && bus.if_valid && !r_squash && !w_take_wait;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT:  if (r_inv_we && (r_inv_idx == C_LAST_IDX)) w_state_next = S_RUN;
            S_RUN:   if (w_gnt) w_state_next = S_WAIT;
            S_WAIT:  if (bus.if_valid) w_state_next = S_RUN;
            default: w_state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_VECTOR;
            r_cap_pc     <= 32'd0;
            r_ready      <= 1'b0;
            r_inv_we     <= 1'b0;
            r_inv_idx    <= '0;
            r_squash     <= 1'b0;
            r_pend_prio  <= 2'd0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            r_inst_valid <= w_deliver;
            if (w_deliver) begin
                r_inst    <= bus.if_rdata;
                r_inst_pc <= r_cap_pc;
            end
            case (r_state)
                S_INIT: begin
                    // First INIT cycle only raises the strobe; index 0 is written next.
                    if (!r_inv_we) begin
                        r_inv_we <= 1'b1;
                    end else if (r_inv_idx == C_LAST_IDX) begin
                        r_inv_we <= 1'b0;
                        r_ready  <= 1'b1;
                    end else begin
                        r_inv_idx <= r_inv_idx + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_take_run) begin
                        r_pc <= w_target;
                        if (w_gnt) begin
                            r_squash    <= 1'b1;
                            r_pend_prio <= w_prio;
                        end
                    end else if (w_gnt) begin
                        r_pc     <= {r_pc[31:2] + 30'd1, 2'b00};
                        r_cap_pc <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (w_take_wait) r_pc <= w_target;
                    if (bus.if_valid) begin
                        r_squash    <= 1'b0;
                        r_pend_prio <= 2'd0;
                    end else if (w_take_wait) begin
                        r_squash    <= 1'b1;
                        r_pend_prio <= w_prio;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready       = r_ready;
    assign inv_we      = r_inv_we;
    assign inv_idx     = r_inv_idx;
    assign bus.if_req  = w_req;
    assign bus.if_addr = r_pc;
    assign inst_valid  = r_inst_valid;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl (ICACHE_SETS=8).
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready, inv_we, inst_valid;
    logic [2:0]  inv_idx;
    logic [31:0] inst, inst_pc;
    logic        stall_hold, hold_pc, flush, branch_flag, predict;
    logic [31:0] flush_pc, branch_target, predict_target;
    int          n_checks = 0;
    int          n_errors = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.ICACHE_SETS(8), .RESET_VECTOR(32'hBFC00000)) u_dut (
        .clk(clk), .rst(rst), .ready(ready), .inv_we(inv_we), .inv_idx(inv_idx),
        .bus(bus.master), .stall_hold(stall_hold), .hold_pc(hold_pc),
        .flush(flush), .flush_pc(flush_pc), .branch_flag(branch_flag),
        .branch_target(branch_target), .predict(predict),
        .predict_target(predict_target), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_hold = 0; hold_pc = 0; flush = 0; branch_flag = 0; predict = 0;
        flush_pc = 0; branch_target = 0; predict_target = 0;
        bus.if_gnt = 0; bus.if_valid = 0; bus.if_rdata = 0;
        step(); step();
        chk("rst_ready", ready, 0);
        chk("rst_inv_we", inv_we, 0);
        chk("rst_inv_idx", inv_idx, 0);
        chk("rst_req", bus.if_req, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_addr", bus.if_addr, 32'hBFC00000);

        // Sweep with a flush held high; it must be ignored.
        rst = 0; flush = 1; flush_pc = 32'h00001234; bus.if_gnt = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("init_we", inv_we, 1);
            chk("init_idx", inv_idx, i);
            chk("init_ready", ready, 0);
            chk("init_addr", bus.if_addr, 32'hBFC00000);
            chk("init_req", bus.if_req, 0);
        end
        flush = 0; bus.if_gnt = 0;
        step();
        chk("run_ready", ready, 1);
        chk("run_we", inv_we, 0);
        chk("run_req", bus.if_req, 1);
        chk("run_addr", bus.if_addr, 32'hBFC00000);

        // Three sequential fetches.
        for (int k = 0; k < 3; k++) begin
            bus.if_gnt = 1;
            step();
            bus.if_gnt = 0; bus.if_valid = 1; bus.if_rdata = 32'hA0000000 + k;
            #1 chk("wait_req", bus.if_req, 0);
            step();
            bus.if_valid = 0;
            chk("seq_valid", inst_valid, 1);
            chk("seq_inst", inst, 32'hA0000000 + k);
            chk("seq_pc", inst_pc, 32'hBFC00000 + 4 * k);
        end
        step();
        chk("pulse_low", inst_valid, 0);
        chk("seq_next_addr", bus.if_addr, 32'hBFC0000C);

        // Redirects during WAIT: predict accepted, flush overrides, later predict ignored.
        bus.if_gnt = 1;
        step();
        bus.if_gnt = 0; predict = 1; predict_target = 32'h80000100;
        step();
        chk("wait_pred_pc", bus.if_addr, 32'h80000100);
        predict = 0; flush = 1; flush_pc = 32'h80000180;
        step();
        flush = 0; predict = 1; predict_target = 32'h80000200;
        step();
        predict = 0;
        chk("wait_lowprio_ign", bus.if_addr, 32'h80000180);
        bus.if_valid = 1; bus.if_rdata = 32'hDEADBEEF;
        step();
        bus.if_valid = 0;
        chk("squash_valid", inst_valid, 0);
        chk("squash_inst_hold", inst, 32'hA0000002);
        chk("after_squash_req", bus.if_req, 1);
        chk("after_squash_addr", bus.if_addr, 32'h80000180);

        // hold_pc masks branch; flush is not masked; branch beats predict.
        stall_hold = 1; hold_pc = 1; branch_flag = 1; branch_target = 32'h90000000;
        step();
        chk("hold_branch", bus.if_addr, 32'h80000180);
        flush = 1; flush_pc = 32'hA0000000;
        step();
        chk("hold_flush", bus.if_addr, 32'hA0000000);
        flush = 0; hold_pc = 0; predict = 1; predict_target = 32'h70000000;
        step();
        chk("branch_over_pred", bus.if_addr, 32'h90000000);
        branch_flag = 0; stall_hold = 0;

        // Redirect coinciding with grant: granted fetch is wrong-path.
        predict_target = 32'hFFFFFFFC; bus.if_gnt = 1;
        step();
        predict = 0; bus.if_gnt = 0; bus.if_valid = 1; bus.if_rdata = 32'h0BAD0BAD;
        step();
        bus.if_valid = 0;
        chk("gnt_redir_squash", inst_valid, 0);
        chk("gnt_redir_addr", bus.if_addr, 32'hFFFFFFFC);

        // Address wrap.
        bus.if_gnt = 1;
        step();
        bus.if_gnt = 0;
        chk("wrap_addr", bus.if_addr, 32'h00000000);
        bus.if_valid = 1; bus.if_rdata = 32'h11111111;
        step();
        bus.if_valid = 0;
        chk("wrap_valid", inst_valid, 1);
        chk("wrap_inst", inst, 32'h11111111);
        chk("wrap_inst_pc", inst_pc, 32'hFFFFFFFC);

        // Stall suppresses requests; grant offered meanwhile is ignored.
        stall_hold = 1; bus.if_gnt = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_req", bus.if_req, 0);
            step();
            chk("stall_addr", bus.if_addr, 32'h00000000);
        end
        stall_hold = 0; bus.if_gnt = 0;
        #1;
        chk("resume_req", bus.if_req, 1);
        chk("resume_addr", bus.if_addr, 32'h00000000);

        // Reset with a fetch outstanding; late response must be dropped.
        bus.if_gnt = 1;
        step();
        bus.if_gnt = 0; rst = 1;
        step();
        rst = 0;
        chk("rst_wait_addr", bus.if_addr, 32'hBFC00000);
        chk("rst_wait_ready", ready, 0);
        chk("rst_wait_req", bus.if_req, 0);
        bus.if_valid = 1; bus.if_rdata = 32'h22222222;
        step();
        bus.if_valid = 0;
        chk("late_valid", inst_valid, 0);
        chk("late_inst", inst, 0);
        step();
        chk("late_valid2", inst_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the instruction-fetch front end. After reset it sweeps I-cache invalidation. It then owns the fetch PC register and issues one fetch request at a time over a req/gnt/valid handshake. Redirects are applied by fixed priority: exception flush, then resolved branch, then branch prediction. Responses from wrong-path fetches are squashed. The block sits between the exception/branch units and the I-cache port and feeds the IF/ID stage.

Parameters:
ICACHE_SETS, 128, number of I-cache sets swept by invalidation (power of two, >=2)
RESET_VECTOR, 32'hBFC00000, PC after reset and during INIT

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ready  output  1  high once invalidation sweep is complete
inv_we  output  1  I-cache tag invalidate strobe
inv_idx  output  $clog2(ICACHE_SETS)  set index being invalidated
if_req  output  1  fetch request valid
if_addr  output  32  fetch address (= pc)
if_gnt  input  1  request accepted this cycle
if_valid  input  1  response data valid (one cycle)
if_rdata  input  32  response instruction
stall_hold  input  1  pipeline stall; suppresses new requests
hold_pc  input  1  ignore branch/predict redirects this cycle
flush  input  1  exception redirect
flush_pc  input  32  exception handler address
branch_flag  input  1  resolved-branch redirect
branch_target  input  32  branch target
predict  input  1  predicted-taken redirect
predict_target  input  32  predicted target
inst_valid  output  1  instruction delivered to decode
inst  output  32  delivered instruction
inst_pc  output  32  address of delivered instruction

Behaviour:
- Reset values: state=INIT, pc=RESET_VECTOR, ready=0, inv_we=0, inv_idx=0, if_req=0, inst_valid=0, inst=0, inst_pc=0, squash=0, pend_prio=0. Reset at any point, including mid-sweep or with a fetch outstanding, returns to these values. A response arriving after reset is ignored.
- Effective redirect each cycle:
  - flush (prio 3) when flush=1.
  - Otherwise branch (prio 2) when branch_flag & ~hold_pc.
  - Otherwise predict (prio 1) when predict & ~hold_pc.
  - Otherwise none (prio 0).
- INIT:
  - inv_we=1 every cycle; inv_idx counts 0..ICACHE_SETS-1.
  - The cycle after idx ICACHE_SETS-1 is written: state->RUN, ready=1, inv_we=0.
  - First request is possible ICACHE_SETS+1 cycles after rst deasserts.
  - All redirects are ignored; pc holds RESET_VECTOR.
- RUN:
  - if_req = ~stall_hold; if_addr = pc.
  - Redirect present: pc<=target.
    - If if_req&if_gnt in the same cycle, the granted fetch is wrong-path: state->WAIT, squash<=1, pend_prio<=prio.
  - Grant with no redirect: pc<={pc[31:2]+30'd1,2'b00} (0xFFFFFFFC wraps to 0); state->WAIT; inst_pc capture register <= old pc.
  - No grant, no redirect: pc holds.
- WAIT (exactly one outstanding fetch):
  - if_req=0.
  - Redirect with prio >= pend_prio: pc<=target, squash<=1, pend_prio<=prio.
  - Redirect with lower prio: ignored.
  - if_valid: state->RUN, pend_prio<=0, squash<=0.
    - If squash=0 (and no same-cycle redirect): inst_valid=1, inst=if_rdata, inst_pc=captured address, registered one cycle later.
    - If squash=1: nothing is delivered.
  - Redirect in the same cycle as if_valid: the redirect wins. The response is squashed and pc<=target.
- inst_valid is a single-cycle pulse; inst/inst_pc hold their last values otherwise.
- stall_hold does not affect an outstanding response or redirect application.
- if_gnt or if_valid outside the states that expect them is ignored.

Test Plan:
- Reset with ICACHE_SETS=8 -> inv_we high for 8 cycles with inv_idx 0..7; ready rises on cycle 9; first if_addr=0xBFC00000.
- Sequential fetch, gnt same cycle, valid next cycle, 3 times -> inst_pc 0xBFC00000, 0xBFC00004, 0xBFC00008 with matching inst, inst_valid pulses.
- predict=1 (target 0x80000100) during WAIT, then flush=1 (0x80000180) and predict=1 (0x80000200) on later WAIT cycles -> response squashed; next if_addr=0x80000180.
- branch_flag=1 with hold_pc=1 in RUN -> pc unchanged; same cycle with flush=1 -> pc=flush_pc.
- pc=0xFFFFFFFC granted -> next if_addr=0x00000000. Assert rst while WAIT -> state INIT; late if_valid produces no inst_valid.
- stall_hold=1 for 5 cycles in RUN -> if_req=0 and pc stable. Deassert -> request resumes at the same pc.
